// File: rtl/gcm_block_sequencer.sv
// ---------------------------------------------------------------------------
// gcm_block_sequencer
//
// Feeds one complete AES-GCM message into the GCM core a 128-bit block at a
// time. The order is: core start pulse, all AD blocks, all plaintext blocks
// (each ciphertext block is returned downstream before the next PT block is
// fetched), the length block, and finally the auth tag is captured.
//
// Ports
//   clk, reset_n           : clock (rising edge), async active-low reset
//   cmd_start              : start request, sampled only while idle
//   ad_blocks, pt_blocks   : block counts, latched with cmd_start
//   in_data/in_valid/in_ready       : upstream block stream (AD then PT)
//   core_start             : one-cycle start pulse to the core
//   core_ad/pt/len + *_valid        : registered block buses + 1-cycle qualifiers
//   core_ciphertext, core_auth_tag  : results from the core
//   out_data/out_valid/out_ready    : downstream ciphertext stream
//   tag, tag_valid         : captured auth tag, held until the next start
//   busy                   : high from accepted start until tag capture
//   dbg_state              : current FSM state encoding
//
// Handshake rule (both streams): a transfer happens on a rising edge where
// valid and ready are both high. The producer holds data and valid stable
// until that edge; ready never depends combinationally on valid.
// ---------------------------------------------------------------------------
module gcm_block_sequencer #(
    parameter int LEN_W        = 8,
    parameter int START_CYCLES = 2,
    parameter int GAP_CYCLES   = 10,
    parameter int TAG_WAIT     = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_start,
    input  logic [LEN_W-1:0] ad_blocks,
    input  logic [LEN_W-1:0] pt_blocks,
    input  logic [127:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             core_start,
    output logic [127:0]     core_ad,
    output logic [127:0]     core_pt,
    output logic [127:0]     core_len,
    output logic             core_ad_valid,
    output logic             core_pt_valid,
    output logic             core_len_valid,
    input  logic [127:0]     core_ciphertext,
    input  logic [127:0]     core_auth_tag,
    output logic [127:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     tag,
    output logic             tag_valid,
    output logic             busy,
    output logic [3:0]       dbg_state
);

    localparam int WAIT_W = 16;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        KICK     = 4'd1,
        SETTLE   = 4'd2,
        AD_FETCH = 4'd3,
        AD_WAIT  = 4'd4,
        PT_FETCH = 4'd5,
        PT_WAIT  = 4'd6,
        CT_OUT   = 4'd7,
        LEN      = 4'd8,
        TAG_HOLD = 4'd9
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    ad_cnt_q, ad_cnt_d;     // AD blocks still to send
    logic [LEN_W-1:0]    pt_cnt_q, pt_cnt_d;     // PT blocks still to send
    logic [LEN_W-1:0]    ad_tot_q, ad_tot_d;     // original counts for the length block
    logic [LEN_W-1:0]    pt_tot_q, pt_tot_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;         // counts N-1 down to 0
    logic                in_ready_q, in_ready_d;
    logic                core_start_q, core_start_d;
    logic [127:0]        core_ad_q, core_ad_d;
    logic [127:0]        core_pt_q, core_pt_d;
    logic [127:0]        core_len_q, core_len_d;
    logic                core_ad_valid_q, core_ad_valid_d;
    logic                core_pt_valid_q, core_pt_valid_d;
    logic                core_len_valid_q, core_len_valid_d;
    logic [127:0]        out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [127:0]        tag_q, tag_d;
    logic                tag_valid_q, tag_valid_d;
    logic                busy_q, busy_d;
    state_e              next_phase;

    // Where to go once a phase is done: remaining AD first, then PT, then LEN.
    // Counters are already decremented by the time any wait expires, so this
    // single rule serves SETTLE, AD_WAIT and CT_OUT.
    always_comb begin
        if (ad_cnt_q != '0) begin
            next_phase = AD_FETCH;
        end else if (pt_cnt_q != '0) begin
            next_phase = PT_FETCH;
        end else begin
            next_phase = LEN;
        end
    end

    always_comb begin
        state_d          = state_q;
        ad_cnt_d         = ad_cnt_q;
        pt_cnt_d         = pt_cnt_q;
        ad_tot_d         = ad_tot_q;
        pt_tot_d         = pt_tot_q;
        wait_d           = wait_q;
        core_start_d     = 1'b0;
        core_ad_d        = core_ad_q;
        core_pt_d        = core_pt_q;
        core_len_d       = core_len_q;
        core_ad_valid_d  = 1'b0;
        core_pt_valid_d  = 1'b0;
        core_len_valid_d = 1'b0;
        out_data_d       = out_data_q;
        out_valid_d      = out_valid_q;
        tag_d            = tag_q;
        tag_valid_d      = tag_valid_q;
        busy_d           = busy_q;

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    ad_cnt_d    = ad_blocks;
                    pt_cnt_d    = pt_blocks;
                    ad_tot_d    = ad_blocks;
                    pt_tot_d    = pt_blocks;
                    busy_d      = 1'b1;
                    tag_valid_d = 1'b0;
                    state_d     = KICK;
                end
            end
            KICK: begin
                core_start_d = 1'b1;
                if (START_CYCLES == 0) begin
                    state_d = next_phase;
                end else begin
                    wait_d  = WAIT_W'(START_CYCLES - 1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (wait_q == '0) begin
                    state_d = next_phase;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            AD_FETCH: begin
                if (in_valid && in_ready_q) begin
                    core_ad_d       = in_data;
                    core_ad_valid_d = 1'b1;
                    ad_cnt_d        = ad_cnt_q - LEN_W'(1);
                    wait_d          = WAIT_W'(GAP_CYCLES - 1);
                    state_d         = AD_WAIT;
                end
            end
            AD_WAIT: begin
                if (wait_q == '0) begin
                    state_d = next_phase;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            PT_FETCH: begin
                if (in_valid && in_ready_q) begin
                    core_pt_d       = in_data;
                    core_pt_valid_d = 1'b1;
                    pt_cnt_d        = pt_cnt_q - LEN_W'(1);
                    wait_d          = WAIT_W'(GAP_CYCLES - 1);
                    state_d         = PT_WAIT;
                end
            end
            PT_WAIT: begin
                if (wait_q == '0) begin
                    out_data_d  = core_ciphertext;
                    out_valid_d = 1'b1;
                    state_d     = CT_OUT;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            CT_OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = next_phase;
                end
            end
            LEN: begin
                // Bit lengths: block count * 128, zero-extended to 64 bits each.
                core_len_d       = {64'({ad_tot_q, 7'b0}), 64'({pt_tot_q, 7'b0})};
                core_len_valid_d = 1'b1;
                wait_d           = WAIT_W'(TAG_WAIT - 1);
                state_d          = TAG_HOLD;
            end
            TAG_HOLD: begin
                if (wait_q == '0) begin
                    tag_d       = core_auth_tag;
                    tag_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered ready: high exactly while the FSM sits in a fetch state.
        in_ready_d = (state_d == AD_FETCH) || (state_d == PT_FETCH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            ad_cnt_q         <= '0;
            pt_cnt_q         <= '0;
            ad_tot_q         <= '0;
            pt_tot_q         <= '0;
            wait_q           <= '0;
            in_ready_q       <= 1'b0;
            core_start_q     <= 1'b0;
            core_ad_q        <= '0;
            core_pt_q        <= '0;
            core_len_q       <= '0;
            core_ad_valid_q  <= 1'b0;
            core_pt_valid_q  <= 1'b0;
            core_len_valid_q <= 1'b0;
            out_data_q       <= '0;
            out_valid_q      <= 1'b0;
            tag_q            <= '0;
            tag_valid_q      <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            ad_cnt_q         <= ad_cnt_d;
            pt_cnt_q         <= pt_cnt_d;
            ad_tot_q         <= ad_tot_d;
            pt_tot_q         <= pt_tot_d;
            wait_q           <= wait_d;
            in_ready_q       <= in_ready_d;
            core_start_q     <= core_start_d;
            core_ad_q        <= core_ad_d;
            core_pt_q        <= core_pt_d;
            core_len_q       <= core_len_d;
            core_ad_valid_q  <= core_ad_valid_d;
            core_pt_valid_q  <= core_pt_valid_d;
            core_len_valid_q <= core_len_valid_d;
            out_data_q       <= out_data_d;
            out_valid_q      <= out_valid_d;
            tag_q            <= tag_d;
            tag_valid_q      <= tag_valid_d;
            busy_q           <= busy_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign core_start     = core_start_q;
    assign core_ad        = core_ad_q;
    assign core_pt        = core_pt_q;
    assign core_len       = core_len_q;
    assign core_ad_valid  = core_ad_valid_q;
    assign core_pt_valid  = core_pt_valid_q;
    assign core_len_valid = core_len_valid_q;
    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign tag            = tag_q;
    assign tag_valid      = tag_valid_q;
    assign busy           = busy_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_gcm_block_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gcm_block_sequencer
//
// Directed bench for gcm_block_sequencer. A message-level model (queues of
// expected AD/PT/CT blocks, length computed as count*128, fixed tag/CT
// latencies) is checked by one monitor on every falling edge; each test adds
// hand-computed literal expectations. The core stub returns
// ciphertext = core_pt ^ ct_mask and a constant auth tag.
// ---------------------------------------------------------------------------
module tb_gcm_block_sequencer;

    localparam int LEN_W = 8;
    localparam int START = 2;
    localparam int GAP   = 10;
    localparam int TWAIT = 10;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic             cmd_start;
    logic [LEN_W-1:0] ad_blocks, pt_blocks;
    logic [127:0]     in_data;
    logic             in_valid, in_ready;
    logic             core_start;
    logic [127:0]     core_ad, core_pt, core_len;
    logic             core_ad_valid, core_pt_valid, core_len_valid;
    logic [127:0]     core_ciphertext, core_auth_tag;
    logic [127:0]     out_data;
    logic             out_valid, out_ready;
    logic [127:0]     tag;
    logic             tag_valid, busy;
    logic [3:0]       dbg_state;

    logic [127:0]     ct_mask, tag_val;
    assign core_ciphertext = core_pt ^ ct_mask;
    assign core_auth_tag   = tag_val;

    gcm_block_sequencer #(
        .LEN_W(LEN_W), .START_CYCLES(START), .GAP_CYCLES(GAP), .TAG_WAIT(TWAIT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start),
        .ad_blocks(ad_blocks), .pt_blocks(pt_blocks),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .core_start(core_start), .core_ad(core_ad), .core_pt(core_pt),
        .core_len(core_len), .core_ad_valid(core_ad_valid),
        .core_pt_valid(core_pt_valid), .core_len_valid(core_len_valid),
        .core_ciphertext(core_ciphertext), .core_auth_tag(core_auth_tag),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .tag(tag), .tag_valid(tag_valid), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [127:0] in_q[$];
    logic [127:0] exp_ad_q[$];
    logic [127:0] exp_pt_q[$];
    logic [127:0] exp_out_q[$];
    logic [127:0] exp_len, exp_tag;
    logic [127:0] last_len, last_out;

    int n_checks = 0, n_fail = 0;
    int n_ad = 0, n_pt = 0, n_out = 0, n_start = 0, n_len = 0, n_tag = 0, n_inready = 0;
    int ct_total = 0, stall_at = 0;
    bit rand_valid = 1'b0;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- upstream feeder ----------------
    initial begin : feeder
        bit hs;
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs && in_q.size() > 0) void'(in_q.pop_front());
            if (in_q.size() > 0) begin
                in_data  = in_q[0];
                in_valid = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
            end
        end
    end

    // ---------------- downstream ready driver ----------------
    initial begin : sink
        bit ov_d;
        int stall_left;
        ov_d = 1'b0;
        stall_left = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid && !ov_d) begin
                ct_total++;
                if (ct_total == stall_at) stall_left = 5;
            end
            ov_d = out_valid;
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // ---------------- monitor / compare ----------------
    initial begin : monitor
        logic [127:0] e, od_prev;
        bit st_prev, ov_prev, or_prev, tv_prev;
        int pt_cyc, len_cyc;
        st_prev = 0; ov_prev = 0; or_prev = 0; tv_prev = 0;
        od_prev = '0; pt_cyc = 0; len_cyc = 0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (core_start) begin
                    n_start++;
                    check_int("core_start_width", int'(st_prev), 0);
                end
                if (core_ad_valid) begin
                    n_ad++;
                    check_int("ad_expected", int'(exp_ad_q.size() != 0), 1);
                    if (exp_ad_q.size() != 0) begin
                        e = exp_ad_q.pop_front();
                        check("core_ad", core_ad, e);
                    end
                end
                if (core_pt_valid) begin
                    n_pt++;
                    pt_cyc = cyc;
                    check_int("pt_expected", int'(exp_pt_q.size() != 0), 1);
                    if (exp_pt_q.size() != 0) begin
                        e = exp_pt_q.pop_front();
                        check("core_pt", core_pt, e);
                    end
                end
                if (out_valid && !ov_prev) check_int("ct_latency", cyc - pt_cyc, GAP);
                if (out_valid && ov_prev && !or_prev) check("out_stable", out_data, od_prev);
                if (out_valid && out_ready) begin
                    n_out++;
                    last_out = out_data;
                    check_int("out_expected", int'(exp_out_q.size() != 0), 1);
                    if (exp_out_q.size() != 0) begin
                        e = exp_out_q.pop_front();
                        check("out_data", out_data, e);
                    end
                end
                if (in_ready) n_inready++;
                if (core_len_valid) begin
                    n_len++;
                    len_cyc  = cyc;
                    last_len = core_len;
                    check("core_len", core_len, exp_len);
                end
                if (tag_valid && !tv_prev) begin
                    n_tag++;
                    check_int("tag_latency", cyc - len_cyc, TWAIT);
                    check("tag", tag, exp_tag);
                    check_int("busy_after_tag", int'(busy), 0);
                end
            end
            st_prev = core_start;
            ov_prev = out_valid;
            or_prev = out_ready;
            od_prev = out_data;
            tv_prev = tag_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_run(input int a, input int p, input logic [127:0] mask,
                            input logic [127:0] tg, input bit rv, input int stall_rel,
                            input bit zero_data);
        logic [127:0] d;
        ct_mask    = mask;
        tag_val    = tg;
        rand_valid = rv;
        for (int i = 0; i < a + p; i++) begin
            d = zero_data ? 128'h0 : {$urandom(), $urandom(), $urandom(), $urandom()};
            in_q.push_back(d);
            if (i < a) begin
                exp_ad_q.push_back(d);
            end else begin
                exp_pt_q.push_back(d);
                exp_out_q.push_back(d ^ mask);
            end
        end
        exp_len  = {64'(a) * 64'd128, 64'(p) * 64'd128};
        exp_tag  = tg;
        stall_at = (stall_rel == 0) ? 0 : ct_total + stall_rel;
    endtask

    // Returns just after edge E, the edge that samples cmd_start.
    task automatic issue_start(input int a, input int p);
        @(posedge clk);
        #1;
        ad_blocks = LEN_W'(a);
        pt_blocks = LEN_W'(p);
        cmd_start = 1'b1;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
    endtask

    task automatic wait_tag(input int base, input int budget);
        int k;
        k = 0;
        while (n_tag == base && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_int("tag_timeout", int'(n_tag != base), 1);
    endtask

    task automatic queues_empty();
        check_int("ad_q_left", exp_ad_q.size(), 0);
        check_int("pt_q_left", exp_pt_q.size(), 0);
        check_int("out_q_left", exp_out_q.size(), 0);
        check_int("in_q_left", in_q.size(), 0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_in_ready"}, 128'(in_ready), 128'h0);
        check({nm, "_core_start"}, 128'(core_start), 128'h0);
        check({nm, "_core_ad"}, core_ad, 128'h0);
        check({nm, "_core_pt"}, core_pt, 128'h0);
        check({nm, "_core_len"}, core_len, 128'h0);
        check({nm, "_valids"}, 128'({core_ad_valid, core_pt_valid, core_len_valid}), 128'h0);
        check({nm, "_out_data"}, out_data, 128'h0);
        check({nm, "_out_valid"}, 128'(out_valid), 128'h0);
        check({nm, "_tag"}, tag, 128'h0);
        check({nm, "_tag_valid"}, 128'(tag_valid), 128'h0);
        check({nm, "_busy"}, 128'(busy), 128'h0);
        check({nm, "_state"}, 128'(dbg_state), 128'h0);
    endtask

    // ---------------- main sequence ----------------
    int b_ad, b_pt, b_out, b_start, b_len, b_tag, b_inr, k;

    task automatic snap();
        b_ad = n_ad; b_pt = n_pt; b_out = n_out; b_start = n_start;
        b_len = n_len; b_tag = n_tag; b_inr = n_inready;
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_start = 1'b0;
        ad_blocks = '0;
        pt_blocks = '0;
        ct_mask   = '0;
        tag_val   = '0;
        exp_len   = '0;
        exp_tag   = '0;
        last_len  = '0;
        last_out  = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Test 1: ad=1, pt=1, literal CT and tag.
        load_run(1, 1, 128'h0123456789ABCDEF0123456789ABCDEF, {16{8'hA5}}, 1'b0, 0, 1'b1);
        snap();
        issue_start(1, 1);
        @(negedge clk);
        @(negedge clk);
        check_int("t1_core_start_e1", int'(core_start), 1);
        check_int("t1_busy_e1", int'(busy), 1);
        @(negedge clk);
        check_int("t1_core_start_e2", int'(core_start), 0);
        wait_tag(b_tag, 2000);
        check_int("t1_ad_pulses", n_ad - b_ad, 1);
        check_int("t1_pt_pulses", n_pt - b_pt, 1);
        check_int("t1_out_xfers", n_out - b_out, 1);
        check("t1_len_lit", last_len, 128'h0000_0000_0000_0080_0000_0000_0000_0080);
        check("t1_out_lit", last_out, 128'h0123456789ABCDEF0123456789ABCDEF);
        check("t1_tag_lit", tag, 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5);
        check_int("t1_tag_valid", int'(tag_valid), 1);
        queues_empty();
        repeat (5) @(negedge clk);

        // Test 2: empty message.
        load_run(0, 0, 128'h0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 0, 1'b0);
        snap();
        issue_start(0, 0);
        wait_tag(b_tag, 500);
        check_int("t2_starts", n_start - b_start, 1);
        check_int("t2_len_pulses", n_len - b_len, 1);
        check("t2_len_lit", last_len, 128'h0);
        check_int("t2_in_ready_cycles", n_inready - b_inr, 0);
        check_int("t2_out_xfers", n_out - b_out, 0);
        check_int("t2_tag_valid", int'(tag_valid), 1);
        repeat (5) @(negedge clk);

        // Test 3: ad=2, pt=3, random in_valid, 5-cycle stall on 2nd CT.
        load_run(2, 3, {4{32'hDEADBEEF}}, {4{32'h0BADF00D}}, 1'b1, 2, 1'b0);
        snap();
        issue_start(2, 3);
        @(negedge clk);
        check_int("t3_tag_valid_cleared", int'(tag_valid), 0);
        wait_tag(b_tag, 3000);
        check_int("t3_ad_pulses", n_ad - b_ad, 2);
        check_int("t3_pt_pulses", n_pt - b_pt, 3);
        check_int("t3_out_xfers", n_out - b_out, 3);
        check("t3_len_lit", last_len, {64'd256, 64'd384});
        queues_empty();
        repeat (5) @(negedge clk);

        // Test 4: second cmd_start while busy in PT_WAIT is ignored.
        load_run(1, 2, {4{32'h5A5A5A5A}}, {4{32'h12345678}}, 1'b0, 0, 1'b0);
        snap();
        issue_start(1, 2);
        k = 0;
        while (n_pt == b_pt && k < 500) begin
            @(negedge clk);
            k++;
        end
        check_int("t4_pt_seen", int'(n_pt != b_pt), 1);
        repeat (3) @(negedge clk);
        issue_start(9, 9);
        @(negedge clk);
        check_int("t4_busy_held", int'(busy), 1);
        wait_tag(b_tag, 2000);
        repeat (30) @(negedge clk);
        check_int("t4_starts", n_start - b_start, 1);
        check_int("t4_pt_pulses", n_pt - b_pt, 2);
        check_int("t4_tags", n_tag - b_tag, 1);
        check_int("t4_busy_idle", int'(busy), 0);
        check("t4_len_lit", last_len, {64'd128, 64'd256});
        queues_empty();

        // Test 5: asynchronous reset during PT_WAIT, then a clean run.
        load_run(1, 1, {4{32'hCAFEF00D}}, {4{32'h77777777}}, 1'b0, 0, 1'b0);
        snap();
        issue_start(1, 1);
        k = 0;
        while (dbg_state != 4'd6 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check_int("t5_reached_pt_wait", int'(dbg_state == 4'd6), 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("t5_async");
        in_q.delete();
        exp_ad_q.delete();
        exp_pt_q.delete();
        exp_out_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        load_run(1, 1, {4{32'h0F0F0F0F}}, {4{32'h99999999}}, 1'b0, 0, 1'b0);
        snap();
        issue_start(1, 1);
        wait_tag(b_tag, 2000);
        check_int("t5_ad_pulses", n_ad - b_ad, 1);
        check_int("t5_out_xfers", n_out - b_out, 1);
        queues_empty();
        repeat (5) @(negedge clk);

        // Test 6: maximum counts.
        load_run(255, 255, {$urandom(), $urandom(), $urandom(), $urandom()},
                 {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 0, 1'b0);
        snap();
        issue_start(255, 255);
        wait_tag(b_tag, 20000);
        check_int("t6_ad_pulses", n_ad - b_ad, 255);
        check_int("t6_pt_pulses", n_pt - b_pt, 255);
        check_int("t6_out_xfers", n_out - b_out, 255);
        check("t6_len_lit", last_len, {64'd32640, 64'd32640});
        queues_empty();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gcm_block_sequencer.md
# gcm_block_sequencer

Control FSM that feeds a complete AES-GCM message into the GCM core (`AES_GCM_Wrapper`) one 128-bit block at a time. It accepts a block stream from upstream and issues the core start pulse. It then sends every AD block, then every plaintext block, then the GCM length block. It returns each ciphertext block downstream and captures the final auth tag. It sits between the system-side message buffer and the GCM datapath. It replaces hand-timed `ad_valid`/`pt_valid` pulsing.

## Interface
Parameters:
- `LEN_W`, 8: width of the block-count inputs.
- `START_CYCLES`, 2: idle cycles after `core_start` before the first block is fetched (≥0).
- `GAP_CYCLES`, 10: cycles the core is given to process each AD/PT block (≥1).
- `TAG_WAIT`, 10: cycles from the length-block pulse to auth-tag capture (≥1).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_start` in 1: start request; sampled only in IDLE.
- `ad_blocks` in LEN_W: number of AD blocks; sampled with `cmd_start`.
- `pt_blocks` in LEN_W: number of plaintext blocks; sampled with `cmd_start`.
- `in_data` in 128: upstream block, AD blocks first, then PT blocks.
- `in_valid` in 1: upstream block valid.
- `in_ready` out 1: sequencer accepts a block.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_ad`, `core_pt`, `core_len` out 128 each: registered block buses to the core.
- `core_ad_valid`, `core_pt_valid`, `core_len_valid` out 1 each: one-cycle qualifiers.
- `core_ciphertext` in 128: ciphertext from the core.
- `core_auth_tag` in 128: auth tag from the core.
- `out_data` out 128: ciphertext block to downstream.
- `out_valid` out 1: downstream block valid.
- `out_ready` in 1: downstream accepts the block.
- `tag` out 128: captured auth tag.
- `tag_valid` out 1: tag valid; held until the next accepted start.
- `busy` out 1: high from an accepted start until tag capture.

## Operation
- Reset: state IDLE. Every output register is zero; this includes `in_ready`, `busy`, `tag` and `tag_valid`.
- States:
  - IDLE
  - KICK
  - SETTLE
  - AD_FETCH
  - AD_WAIT
  - PT_FETCH
  - PT_WAIT
  - CT_OUT
  - LEN
  - TAG_HOLD
- IDLE:
  - On `cmd_start`, latch `ad_blocks`/`pt_blocks` into the remaining-block counters.
  - Set `busy`, clear `tag_valid`, go to KICK.
- KICK: `core_start`=1 for exactly one cycle, then go to SETTLE.
- SETTLE: lasts START_CYCLES cycles (0 means pass straight through). Then go to:
  - AD_FETCH if the AD count is nonzero;
  - else PT_FETCH if the PT count is nonzero;
  - else LEN.
- AD_FETCH: `in_ready`=1. On `in_valid`&`in_ready`:
  - `core_ad`<=`in_data`, `core_ad_valid`<=1 for one cycle;
  - decrement the AD count;
  - go to AD_WAIT.
- AD_WAIT: lasts GAP_CYCLES cycles. Then go to AD_FETCH if AD blocks remain, else PT_FETCH or LEN by the same rule as SETTLE.
- PT_FETCH: same handshake as AD_FETCH, driving `core_pt`/`core_pt_valid`. Then go to PT_WAIT.
- PT_WAIT: lasts GAP_CYCLES cycles. On its last edge, `out_data`<=`core_ciphertext`, `out_valid`<=1, go to CT_OUT.
- CT_OUT:
  - Hold `out_data`/`out_valid` stable until `out_valid`&`out_ready`.
  - Clear `out_valid` on that edge.
  - Go to PT_FETCH if PT blocks remain, else LEN.
  - No timeout.
- LEN: `core_len` = {64-bit AD bit length, 64-bit PT bit length}. Each field is the zero-extended {count, 7'b0}. `core_len_valid`=1 for one cycle. Go to TAG_HOLD.
- TAG_HOLD: lasts TAG_WAIT cycles. On its last edge:
  - `tag`<=`core_auth_tag`, `tag_valid`<=1;
  - `busy`<=0;
  - go to IDLE.
- `cmd_start` while `busy` is ignored; the latched counts are unchanged.
- `in_valid` outside the FETCH states is ignored, because `in_ready`=0 there.
- `reset_n` low in any state: outputs drop to their reset values immediately and the FSM returns to IDLE. The core shares the same reset. Nothing is replayed.

## Timing
- `cmd_start` sampled at edge E → `busy` high and `core_start` high after E+1. `core_start` low after E+2.
- Block handshake at edge H: `core_*_valid` and `core_*` update at H and the valid is high for cycle H..H+1 only.
- Ciphertext sampling: `core_ciphertext` is sampled at edge H+GAP_CYCLES, and `out_valid` is high from H+GAP_CYCLES onward.
- Tag capture: the `core_len_valid` pulse is set at edge L, and the tag is captured at edge L+TAG_WAIT.
- Wait counters count down from N-1 to 0, one decrement per cycle.
- Block counts wrap nowhere: the maximum is 2^LEN_W−1. A count of 0 skips that phase entirely.
- All outputs are registered; there is no combinational input→output path.

## Test plan
- ad=1, pt=1, defaults, core stub returns CT=0x0123…EF and tag=0xA5…A5:
  - exactly one `core_ad_valid` and one `core_pt_valid` pulse;
  - `core_len`=128'h…0080_…0080;
  - `out_data`=0x0123…EF;
  - `tag_valid` 10 cycles after `core_len_valid`.
- ad=0, pt=0:
  - `core_start`, then `core_len_valid` with `core_len`=0;
  - `in_ready` never high, `out_valid` never high;
  - `tag_valid` set.
- ad=2, pt=3, `in_valid` toggled randomly, `out_ready` low for 5 cycles on the 2nd CT:
  - `out_data` holds stable while stalled;
  - exactly 3 output transfers;
  - `core_len`={64'd256,64'd384}.
- `cmd_start` pulsed again mid-PT_WAIT: ignored, `busy` stays 1, block counts unaffected, single tag result.
- `reset_n` low during PT_WAIT:
  - all outputs 0 asynchronously;
  - after release, a new ad=1/pt=1 run completes normally.
- ad=255, pt=255: 255+255 handshakes, `core_len`={64'd32640,64'd32640}.
